alu_exec_ctrl: RTL

Execute-stage controller wrapped around the combinational 16-bit ALU (opcodes 000 ADD … 111 MOV; flags {Z,CY,S,P,OV}).
- Accepts one decoded instruction per handshake.
- Reads operands from an internal register file and drives the ALU ports.
- Registers the ALU result and flags, then writes back to the register file and the flag register.
- Sits between the decoder (upstream) and the ALU (feeds it, consumes its outputs).

---
 rtl/alu_exec_ctrl_pkg.sv | 45 ++++
 rtl/alu_regfile.sv | 36 +++
 rtl/alu_exec_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/alu_exec_ctrl_pkg.sv
// rtl/alu_exec_ctrl_pkg.sv - shared opcodes, flag indices, FSM states and instruction record for alu_exec_ctrl
package alu_exec_ctrl_pkg;

  localparam int PKG_DATA_W = 16;
  localparam int PKG_ADDR_W = 3;
  localparam int FLG_W      = 5;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_NOT  = 3'b101;
  localparam logic [2:0] OP_MOV0 = 3'b110;
  localparam logic [2:0] OP_MOV1 = 3'b111;

  localparam int FLG_Z  = 4;
  localparam int FLG_CY = 3;
  localparam int FLG_S  = 2;
  localparam int FLG_P  = 1;
  localparam int FLG_OV = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  typedef struct packed {
    logic [2:0]            op;
    logic [PKG_ADDR_W-1:0] rd;
    logic [PKG_ADDR_W-1:0] rs1;
    logic [PKG_ADDR_W-1:0] rs2;
    logic                  use_imm;
    logic [PKG_DATA_W-1:0] imm;
    logic                  hold_flags;
    logic                  wb_en;
  } instr_t;

  // The ALU leaves CY/OV undefined for both MOV encodings.
  function automatic logic is_mov(input logic [2:0] op);
    return op[2:1] == 2'b11;
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// rtl/alu_regfile.sv - general register file with two read ports, a debug port and one write port
module alu_regfile #(
  parameter int DATA_W  = 16,
  parameter int REG_CNT = 8,
  parameter int ADDR_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] mem [REG_CNT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_CNT; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata1   = mem[raddr1];
  assign rdata2   = mem[raddr2];
  assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_exec_ctrl.sv
// rtl/alu_exec_ctrl.sv - execute-stage controller: latch instruction, feed external ALU, capture, write back
module alu_exec_ctrl
  import alu_exec_ctrl_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int REG_CNT = 8,
  parameter int ADDR_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        instr_op,
  input  logic [ADDR_W-1:0] instr_rd,
  input  logic [ADDR_W-1:0] instr_rs1,
  input  logic [ADDR_W-1:0] instr_rs2,
  input  logic              instr_use_imm,
  input  logic [DATA_W-1:0] instr_imm,
  input  logic              instr_hold_flags,
  input  logic              instr_wb_en,
  output logic [2:0]        alu_opcode,
  output logic [DATA_W-1:0] alu_arg1,
  output logic [DATA_W-1:0] alu_arg2,
  output logic [4:0]        alu_in_flg,
  output logic              alu_block_cy_ov,
  input  logic [DATA_W-1:0] alu_res,
  input  logic [4:0]        alu_out_flg,
  output logic [4:0]        flags,
  output logic              busy,
  output logic              done,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  state_t            state;
  instr_t            ir;
  logic [DATA_W-1:0] res_q;
  logic [4:0]        flg_q;
  logic [4:0]        next_flags;
  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;
  logic              rf_we;

  assign rf_we = (state == ST_WB) && ir.wb_en;

  alu_regfile #(
    .DATA_W (DATA_W),
    .REG_CNT(REG_CNT),
    .ADDR_W (ADDR_W)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (rf_we),
    .waddr   (ir.rd),
    .wdata   (res_q),
    .raddr1  (ir.rs1),
    .rdata1  (rs1_data),
    .raddr2  (ir.rs2),
    .rdata2  (rs2_data),
    .dbg_addr(dbg_addr),
    .dbg_data(dbg_data)
  );

  // ALU drive comes only from registered state, so it is stable and X-free in every state.
  assign alu_opcode      = ir.op;
  assign alu_block_cy_ov = ir.hold_flags;
  assign alu_arg1        = rs1_data;
  assign alu_arg2        = ir.use_imm ? ir.imm : rs2_data;
  assign alu_in_flg      = flags;

  always_comb begin
    next_flags = flg_q;
    if (is_mov(ir.op)) begin
      next_flags[FLG_CY] = flags[FLG_CY];
      next_flags[FLG_OV] = flags[FLG_OV];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      ir          <= '0;
      res_q       <= '0;
      flg_q       <= '0;
      flags       <= '0;
      instr_ready <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (instr_valid) begin
            ir.op         <= instr_op;
            ir.rd         <= instr_rd;
            ir.rs1        <= instr_rs1;
            ir.rs2        <= instr_rs2;
            ir.use_imm    <= instr_use_imm;
            ir.imm        <= instr_imm;
            ir.hold_flags <= instr_hold_flags;
            ir.wb_en      <= instr_wb_en;
            state         <= ST_EXEC;
            instr_ready   <= 1'b0;
            busy          <= 1'b1;
          end
        end
        ST_EXEC: begin
          res_q <= alu_res;
          flg_q <= alu_out_flg;
          state <= ST_WB;
          done  <= 1'b1;
        end
        ST_WB: begin
          flags       <= next_flags;
          state       <= ST_IDLE;
          done        <= 1'b0;
          instr_ready <= 1'b1;
          busy        <= 1'b0;
        end
        default: begin
          state       <= ST_IDLE;
          done        <= 1'b0;
          instr_ready <= 1'b1;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule
